// File: rtl/mem_access_unit_if.sv
// Bus bundle for the load/store unit: execute-stage request, dmemory port,
// writeback result and fault pulse. The unit takes the slave view; whoever
// drives the requests and owns the memory takes the master view.
interface mem_access_unit_if;
    // execute stage -> unit
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    // unit <-> dmemory
    logic [1:0]  dm_access_size;
    logic [31:0] dm_address;
    logic [31:0] dm_data_in;
    logic        dm_rw;
    logic        dm_is_signed;
    logic [31:0] dm_data_out;
    // unit -> writeback
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data, ex_rd,
        input  dm_data_out,
        output ex_ready,
        output dm_access_size, dm_address, dm_data_in, dm_rw, dm_is_signed,
        output wb_valid, wb_rd, wb_data, fault
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data, ex_rd,
        output dm_data_out,
        input  ex_ready,
        input  dm_access_size, dm_address, dm_data_in, dm_rw, dm_is_signed,
        input  wb_valid, wb_rd, wb_data, fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller between execute and dmemory. Accepts one op per
// handshake, decodes RV32I funct3 into dmemory size/sign controls, and splits
// misaligned half/word accesses into sequential byte accesses when enabled.
//
//   state  | meaning
//   IDLE   | no access in flight, ready for a new op
//   ACCESS | single aligned access this cycle, ready for the next op
//   SPLIT  | byte k of a misaligned access this cycle, not ready
module mem_access_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10
    } state_t;

    state_t      r_state;
    logic        r_is_load;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    logic [1:0]  r_k;
    logic [31:0] r_acc;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_fault;

    logic        w_ready;
    logic        w_accept;
    logic        w_legal_load;
    logic        w_legal_store;
    logic        w_illegal;
    logic        w_misaligned;
    logic [1:0]  w_last_k;
    logic [31:0] w_acc_next;
    logic [31:0] w_split_result;
    logic        w_rw;

    assign w_ready  = (r_state != SPLIT);
    assign w_accept = bus.ex_valid & w_ready;

    assign w_legal_load  = (bus.ex_funct3 == 3'b000) | (bus.ex_funct3 == 3'b001) |
                           (bus.ex_funct3 == 3'b010) | (bus.ex_funct3 == 3'b100) |
                           (bus.ex_funct3 == 3'b101);
    assign w_legal_store = (bus.ex_funct3 == 3'b000) | (bus.ex_funct3 == 3'b001) |
                           (bus.ex_funct3 == 3'b010);
    assign w_illegal     = (bus.ex_is_load & bus.ex_is_store) |
                           (bus.ex_is_load  & ~w_legal_load) |
                           (bus.ex_is_store & ~w_legal_store);
    // Only meaningful for legal ops; illegal ones fault regardless.
    assign w_misaligned  = ((bus.ex_funct3[1:0] == 2'b01) & bus.ex_addr[0]) |
                           ((bus.ex_funct3[1:0] == 2'b10) & (bus.ex_addr[1:0] != 2'b00));

    assign w_last_k = (r_funct3[1:0] == 2'b10) ? 2'd3 : 2'd1;

    // Accumulator with the byte returned this SPLIT cycle merged in.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_k, 3'b000} +: 8] = bus.dm_data_out[7:0];
    end

    // Final split-load value: halves extend from bit 15, words pass through.
    always_comb begin
        w_split_result = w_acc_next;
        if (r_funct3[1:0] == 2'b01) begin
            w_split_result = {{16{~r_funct3[2] & w_acc_next[15]}}, w_acc_next[15:0]};
        end
    end

    // dmemory port drive; idle values whenever no access is in flight.
    always_comb begin
        bus.dm_access_size = 2'b11;
        bus.dm_address     = 32'h0;
        bus.dm_data_in     = 32'h0;
        bus.dm_is_signed   = 1'b0;
        w_rw               = 1'b0;
        case (r_state)
            ACCESS: begin
                bus.dm_access_size = r_funct3[1:0];
                bus.dm_address     = r_addr;
                bus.dm_data_in     = r_data;
                bus.dm_is_signed   = r_is_load & ~r_funct3[2];
                w_rw               = r_is_store;
            end
            SPLIT: begin
                bus.dm_access_size = 2'b00;
                bus.dm_address     = r_addr + {30'h0, r_k};
                bus.dm_data_in     = r_data >> {r_k, 3'b000};
                w_rw               = r_is_store;
            end
            default: ;
        endcase
    end

    // Gated by reset so an abandoned store never lands on the reset edge.
    assign bus.dm_rw    = w_rw & reset_n;
    assign bus.ex_ready = w_ready;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;
    assign bus.fault    = r_fault;

    // Main FSM: op capture on accept, access sequencing, writeback and fault pulses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_data     <= 32'h0;
            r_rd       <= 5'd0;
            r_k        <= 2'd0;
            r_acc      <= 32'h0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'h0;
            r_fault    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_fault    <= 1'b0;

            case (r_state)
                ACCESS: begin
                    if (r_is_load) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= bus.dm_data_out;
                    end
                end
                SPLIT: begin
                    r_acc <= w_acc_next;
                    if (r_k == w_last_k) begin
                        r_k     <= 2'd0;
                        r_state <= IDLE;
                        if (r_is_load) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_split_result;
                        end
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                default: ;
            endcase

            if (w_accept) begin
                r_is_load  <= bus.ex_is_load;
                r_is_store <= bus.ex_is_store;
                r_funct3   <= bus.ex_funct3;
                r_addr     <= bus.ex_addr;
                r_data     <= bus.ex_store_data;
                r_rd       <= bus.ex_rd;
                if (!bus.ex_is_load && !bus.ex_is_store) begin
                    r_state <= IDLE;
                end else if (w_illegal || (w_misaligned && !SPLIT_MISALIGNED)) begin
                    r_fault <= 1'b1;
                    r_state <= IDLE;
                end else if (w_misaligned) begin
                    r_k     <= 2'd0;
                    r_acc   <= 32'h0;
                    r_state <= SPLIT;
                end else begin
                    r_state <= ACCESS;
                end
            end else if (r_state == ACCESS) begin
                r_state <= IDLE;
            end
        end
    end

endmodule
